mult_share_ctrl: RTL and testbench
==================================

MULT_SHARE_CTRL -- requirements
Module: mult_share_ctrl

Interface
REQ-001 SHALL have parameter OPW, default 8, meaning operand width; only the value 8 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports req0/req1  input  1  per-requester multiply request; held high until the matching done pulse.
REQ-005 SHALL have ports a0/b0 and a1/b1  input  8 each  unsigned operands for requester 0 and 1; sampled only when that requester is granted.
REQ-006 SHALL have port busy  output  1  high while an operation is in progress (states MUL and DONE).
REQ-007 SHALL have port grant  output  1  index of the requester currently or most recently served.
REQ-008 SHALL have ports done0/done1  output  1 each  one-cycle completion pulse to the served requester.
REQ-009 SHALL have port product  output  16  unsigned a*b of the last completed operation.

Function
REQ-010 SHALL instantiate exactly one 4x4 unsigned combinational array multiplier (M4bit) and compute each 8x8 product by time-multiplexing it over four nibble passes.
REQ-011 SHALL implement FSM states IDLE, MUL, DONE; reset state IDLE.
REQ-012 IDLE: if any req is high, SHALL grant one requester, latch its a/b into internal operand registers, clear the 16-bit accumulator, set pass counter to 0, and go to MUL; otherwise stay in IDLE.
REQ-013 Arbitration SHALL be round-robin: on a single request, grant it; on simultaneous requests, grant the requester not served last; after reset, requester 0 wins a tie.
REQ-014 MUL: pass k=0..3 SHALL feed nibble pairs (aL,bL), (aL,bH), (aH,bL), (aH,bH) and add the 8-bit partial product shifted left by 0, 4, 4, 8 into the accumulator.
REQ-015 After pass 3, SHALL go to DONE; MUL SHALL last exactly 4 cycles.
REQ-016 DONE: SHALL drive product with the final accumulator value, pulse the granted requester's done for exactly one cycle, and go to IDLE.
REQ-017 Latency: request accepted on edge t -> done pulse and valid product during the cycle after edge t+5; throughput one product per 6 cycles.
REQ-018 Accumulator arithmetic SHALL be 16-bit unsigned with no overflow possible (max 255*255 = 65025).
REQ-019 product and grant SHALL hold their values until the next DONE or reset.
REQ-020 Requests arriving while busy SHALL be ignored until IDLE; operand changes after acceptance SHALL NOT affect the result.
REQ-021 A req deasserted mid-operation SHALL NOT abort it; the done pulse still occurs.
REQ-022 A req still high in the IDLE cycle following its done SHALL be treated as a new request, subject to round-robin.
REQ-023 done0 and done1 SHALL never be high in the same cycle.

Reset
REQ-024 On rst high at a clock edge, SHALL set state IDLE, busy=0, done0=done1=0, product=0, grant=0, accumulator and operand registers to 0, and the round-robin pointer to favour requester 0.
REQ-025 rst during MUL or DONE SHALL abort the operation with no done pulse; rst SHALL take priority over all other inputs.

Verification
REQ-026 After reset, req0=1, a0=8'hFF, b0=8'hFF -> busy high for 5 cycles, done0 single pulse, product=16'hFE01, done1 never high.
REQ-027 req0 and req1 asserted together, a0=12, b0=10, a1=7, b1=9, both held until their done -> done0 first with product=16'h0078, done1 six cycles later with product=16'h003F.
REQ-028 req0 and req1 held high continuously for 4 operations -> grant sequence 0,1,0,1, and done pulses alternate with 6-cycle spacing.
REQ-029 req1, a1=0, b1=200, then req1 dropped after 1 cycle and a1/b1 changed to 8'hAA -> done1 still pulses and product=16'h0000.
REQ-030 req0 with a0=8'h5A, b0=8'h3C, rst asserted in the second MUL cycle -> no done pulse, next-cycle busy=0 and product=0; a fresh req0 then yields product=16'h1518.
REQ-031 Random operands on both requesters for 1000 operations -> each product equals the reference a*b, and no request is starved for more than one operation.

Source files
------------

// File: rtl/mult_share_ctrl.sv
// Shared 8x8 unsigned multiplier controller: two requesters take turns on a
// single 4x4 array multiplier. Each 8x8 product is built from four nibble
// passes into a 16-bit accumulator. Arbitration is round-robin.

// 4x4 unsigned combinational array multiplier.
module m4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  // Sum one shifted copy of a for each set bit of b.
  always_comb begin
    // NOTE: p gets a default before the loop, so every path assigns it and no latch is inferred.
    p = '0;
    for (int i = 0; i < 4; i++) begin
      // NOTE: these are blocking assignments because each row adds onto the sum built by the rows before it in the same pass.
      if (b[i]) p = p + ({4'b0000, a} << i);
    end
  end

endmodule

module mult_share_ctrl #(
  parameter int OPW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [OPW-1:0]   a0,
  input  logic [OPW-1:0]   b0,
  input  logic [OPW-1:0]   a1,
  input  logic [OPW-1:0]   b1,
  output logic             busy,
  output logic             grant,
  output logic             done0,
  output logic             done1,
  output logic [2*OPW-1:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [OPW-1:0]   op_a;
  logic [OPW-1:0]   op_b;
  logic [2*OPW-1:0] acc;
  logic [1:0]       pass;
  logic             prio;      // requester that wins the next tie
  logic             accept;
  logic             sel;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [7:0]       pp;
  logic [15:0]      pp_shift;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registers. Every flop then samples values from before the edge, whatever the block order.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state and round-robin selection. A tie goes to prio. A single request goes to whoever asked.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    sel        = prio;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          accept     = 1'b1;
          next_state = MUL;
          sel        = (req0 && req1) ? prio : req1;
        end
      end
      MUL:     if (pass == 2'd3) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == MUL) || (state == DONE);

  // Pass k picks nibbles: bit 1 selects the a half, bit 0 selects the b half.
  always_comb begin
    nib_a = pass[1] ? op_a[7:4] : op_a[3:0];
    nib_b = pass[0] ? op_b[7:4] : op_b[3:0];
  end

  m4bit u_m4bit (
    .a (nib_a),
    .b (nib_b),
    .p (pp)
  );

  // Align the partial product: the shift is 0, 4, 4, 8 for passes 0..3.
  always_comb begin
    case (pass)
      2'd0:       pp_shift = {8'h00, pp};
      2'd1, 2'd2: pp_shift = {4'h0, pp, 4'h0};
      default:    pp_shift = {pp, 8'h00};
    endcase
  end

  // Datapath: operand capture, accumulation, registered product and done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      acc     <= '0;
      pass    <= 2'd0;
      prio    <= 1'b0;
      grant   <= 1'b0;
      product <= '0;
      done0   <= 1'b0;
      done1   <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (accept) begin
        grant <= sel;
        prio  <= ~sel;
        op_a  <= sel ? a1 : a0;
        op_b  <= sel ? b1 : b0;
        acc   <= '0;
        pass  <= 2'd0;
      end
      if (state == MUL) begin
        acc  <= acc + pp_shift;
        pass <= pass + 2'd1;
      end
      if (state == DONE) begin
        product <= acc;
        done0   <= ~grant;
        done1   <= grant;
      end
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl. Expected products go into a queue
// per requester when a request is raised. A negedge monitor pops and compares
// them on each done pulse.
module tb_mult_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [7:0]  a0, b0, a1, b1;
  logic        busy, grant, done0, done1;
  logic [15:0] product;

  int n_cmp = 0;
  int n_bad = 0;
  int done0_cnt = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];

  typedef struct {
    logic        r;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  mult_share_ctrl #(.OPW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .a0      (a0),
    .b0      (b0),
    .a1      (a1),
    .b1      (b1),
    .busy    (busy),
    .grant   (grant),
    .done0   (done0),
    .done1   (done1),
    .product (product)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v);
    if (r == 1) req1 = v;
    else        req0 = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    tick();
    tick();
    rst = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  // Scoreboard monitor: compares product against the queued expectation on every done pulse.
  always @(negedge clk) begin
    if (!rst && (done0 || done1)) begin
      check("done_exclusive", {31'b0, done0 & done1}, 32'd0);
      if (done0) begin
        done0_cnt++;
        if (q0.size() == 0) flag("done0_unexpected", "pulse with nothing outstanding");
        else check("product_r0", {16'b0, product}, {16'b0, q0.pop_front()});
      end
      if (done1) begin
        if (q1.size() == 0) flag("done1_unexpected", "pulse with nothing outstanding");
        else check("product_r1", {16'b0, product}, {16'b0, q1.pop_front()});
      end
    end
  end

  // Step clock edges until a done pulse shows, up to a bounded number of edges.
  task automatic wait_any(input int budget, output int edges, output int busy_n,
                          output logic d0, output logic d1);
    edges = 0; busy_n = 0; d0 = 1'b0; d1 = 1'b0;
    while (edges < budget) begin
      tick();
      edges++;
      if (done0 || done1) begin
        d0 = done0;
        d1 = done1;
        break;
      end
      if (busy) busy_n++;
    end
    if (!(d0 || d1)) flag("timeout", "no done pulse within budget");
  endtask

  // One isolated operation on requester r, with latency, busy length and grant checked.
  task automatic run_op(input logic r, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input string name);
    int e, bn;
    logic d0, d1;
    if (r) begin a1 = a; b1 = b; req1 = 1'b1; q1.push_back(exp); end
    else   begin a0 = a; b0 = b; req0 = 1'b1; q0.push_back(exp); end
    wait_any(12, e, bn, d0, d1);
    check({name, "_done"}, {31'b0, r ? d1 : d0}, 32'd1);
    check({name, "_latency"}, e, 32'd6);
    check({name, "_busy_cycles"}, bn, 32'd5);
    check({name, "_grant"}, {31'b0, grant}, {31'b0, r});
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic issue(input int r, ref int wait_ops[2]);
    logic [7:0] a, b;
    a = 8'($urandom_range(255));
    b = 8'($urandom_range(255));
    if (r == 1) begin a1 = a; b1 = b; q1.push_back(16'(a) * 16'(b)); end
    else        begin a0 = a; b0 = b; q0.push_back(16'(a) * 16'(b)); end
    set_req(r, 1'b1);
    wait_ops[r] = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, bn, ops, guard, r, cnt_before;
    int wait_ops[2];
    int idle_t[2];
    logic d0, d1;

    vecs[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{1'b1, 8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{1'b0, 8'h00, 8'h00, 16'h0000};
    vecs[3] = '{1'b1, 8'h0F, 8'hF0, 16'h0E10};
    vecs[4] = '{1'b0, 8'hF0, 8'h0F, 16'h0E10};
    vecs[5] = '{1'b1, 8'hAB, 8'hCD, 16'h88EF};
    vecs[6] = '{1'b0, 8'h01, 8'hFF, 16'h00FF};
    vecs[7] = '{1'b1, 8'h80, 8'h02, 16'h0100};
    vecs[8] = '{1'b0, 8'h10, 8'h10, 16'h0100};
    vecs[9] = '{1'b1, 8'h5A, 8'h3C, 16'h1518};

    // Reset state.
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    a0 = 8'h11; b0 = 8'h22; a1 = 8'h33; b1 = 8'h44;
    tick();
    tick();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done0", {31'b0, done0}, 32'd0);
    check("rst_done1", {31'b0, done1}, 32'd0);
    check("rst_product", {16'b0, product}, 32'd0);
    check("rst_grant", {31'b0, grant}, 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    rst = 1'b0;
    tick();

    // Table of isolated operations.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
      tick();
    end
    repeat (4) tick();
    check("product_hold", {16'b0, product}, 32'h1518);
    check("grant_hold", {31'b0, grant}, 32'd1);

    // Simultaneous requests after reset: requester 0 wins, requester 1 follows six cycles later.
    do_reset();
    a0 = 8'd12; b0 = 8'd10; a1 = 8'd7; b1 = 8'd9;
    q0.push_back(16'h0078);
    q1.push_back(16'h003F);
    req0 = 1'b1; req1 = 1'b1;
    wait_any(12, e, bn, d0, d1);
    check("tie_first_done0", {31'b0, d0}, 32'd1);
    check("tie_first_lat", e, 32'd6);
    check("tie_first_grant", {31'b0, grant}, 32'd0);
    req0 = 1'b0;
    wait_any(12, e, bn, d0, d1);
    check("tie_second_done1", {31'b0, d1}, 32'd1);
    check("tie_second_spacing", e, 32'd6);
    check("tie_second_grant", {31'b0, grant}, 32'd1);
    req1 = 1'b0;

    // Both held continuously: grants alternate 0,1,0,1 with 6-cycle spacing.
    do_reset();
    a0 = 8'd3; b0 = 8'd5; a1 = 8'd4; b1 = 8'd6;
    q0.push_back(16'd15); q0.push_back(16'd15);
    q1.push_back(16'd24); q1.push_back(16'd24);
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_any(12, e, bn, d0, d1);
      check($sformatf("rr%0d_done1", i), {31'b0, d1}, 32'(i % 2));
      check($sformatf("rr%0d_spacing", i), e, 32'd6);
      check($sformatf("rr%0d_grant", i), {31'b0, grant}, 32'(i % 2));
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (8) tick();

    // Request dropped and operands changed after acceptance: the operation still completes unchanged.
    a1 = 8'd0; b1 = 8'd200;
    q1.push_back(16'h0000);
    req1 = 1'b1;
    tick();
    req1 = 1'b0; a1 = 8'hAA; b1 = 8'hAA;
    wait_any(12, e, bn, d0, d1);
    check("drop_done1", {31'b0, d1}, 32'd1);
    check("drop_lat", e, 32'd5);
    repeat (3) tick();

    // Reset in the second MUL cycle aborts the operation without a done pulse.
    run_op(1'b0, 8'h12, 8'h34, 16'h03A8, "pre_abort");
    tick();
    a0 = 8'h5A; b0 = 8'h3C; req0 = 1'b1;
    tick();
    tick();
    cnt_before = done0_cnt;
    rst = 1'b1; req0 = 1'b0;
    tick();
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_product", {16'b0, product}, 32'd0);
    check("abort_grant", {31'b0, grant}, 32'd0);
    check("abort_done0", {31'b0, done0}, 32'd0);
    rst = 1'b0;
    repeat (8) tick();
    check("abort_no_done", done0_cnt, cnt_before);
    run_op(1'b0, 8'h5A, 8'h3C, 16'h1518, "post_abort");

    // Random operands on both requesters, with random idle gaps between requests.
    do_reset();
    ops = 0; guard = 0;
    idle_t[0] = 0; idle_t[1] = 0;
    issue(0, wait_ops);
    issue(1, wait_ops);
    while (ops < 1000 && guard < 30000) begin
      tick();
      guard++;
      if (done0 || done1) begin
        r = done1 ? 1 : 0;
        ops++;
        check("rand_no_starve", {31'b0, wait_ops[r] <= 1}, 32'd1);
        if (((1 - r) == 1) ? req1 : req0) wait_ops[1 - r]++;
        if ($urandom_range(3) != 0) issue(r, wait_ops);
        else begin
          set_req(r, 1'b0);
          idle_t[r] = int'($urandom_range(8, 1));
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (!((k == 1) ? req1 : req0) && idle_t[k] > 0) begin
          idle_t[k]--;
          if (idle_t[k] == 0) issue(k, wait_ops);
        end
      end
    end
    if (ops < 1000) flag("rand_timeout", $sformatf("only %0d of 1000 operations completed", ops));
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
